// File: rtl/catraca_pkg.sv
// Shared types and defaults for the two-reader turnstile controller.
package catraca_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        LIBERADA = 2'd1,
        NEGADO   = 2'd2
    } estado_t;

    localparam int MAX_SALDO_DEF      = 5;
    localparam int TEMPO_LIBERADA_DEF = 4;
    localparam int MAX_CONTA_DEF      = 99;
    localparam int SALDO_W            = 3;
    localparam int CONTA_W            = 7;
    localparam int TIMER_W            = 4;

    // Recharge adds in one extra bit so an overflow past the ceiling still clamps.
    function automatic logic [SALDO_W-1:0] soma_sat(
        input logic [SALDO_W-1:0] a,
        input logic [1:0]         b,
        input logic [SALDO_W-1:0] lim
    );
        logic [SALDO_W:0] s;
        s = {1'b0, a} + {{(SALDO_W-1){1'b0}}, b};
        return (s > {1'b0, lim}) ? lim : s[SALDO_W-1:0];
    endfunction

endpackage

// File: rtl/catraca_controlador_arbitro_rr2.sv
// Two-requester round-robin arbiter; on a tie the reader not granted last wins.
module arbitro_rr2 (
    input  logic [1:0] pend_i,
    input  logic       ult_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (pend_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ult_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/catraca_controlador.sv
// Turnstile controller shared by two card readers: credit, unlock, passenger count.
// Define CATRACA_ESTORNO_EN to refund the credit when an unlock times out unused.
module catraca_controlador
    import catraca_pkg::*;
#(
    parameter int MAX_SALDO      = MAX_SALDO_DEF,
    parameter int TEMPO_LIBERADA = TEMPO_LIBERADA_DEF,
    parameter int MAX_CONTA      = MAX_CONTA_DEF
) (
    input  logic               clk_2,
    input  logic               reset,
    input  logic [1:0]         passe,
    input  logic [1:0]         carrega1,
    input  logic [1:0]         carrega2,
    input  logic               giro,
    output logic               catraca,
    output logic [1:0]         atendido,
    output logic               erro,
    output logic [SALDO_W-1:0] saldo1,
    output logic [SALDO_W-1:0] saldo2,
    output logic [CONTA_W-1:0] conta
);

    localparam logic [SALDO_W-1:0] SALDO_LIM = SALDO_W'(MAX_SALDO);
    localparam logic [CONTA_W-1:0] CONTA_LIM = CONTA_W'(MAX_CONTA);
    localparam logic [TIMER_W-1:0] TIMER_FIM = TIMER_W'(TEMPO_LIBERADA - 1);

    estado_t              estado_q, estado_d;
    logic [1:0]           passe_q;
    logic [1:0]           pend_q, pend_d;
    logic                 ult_q, ult_d;
    logic [SALDO_W-1:0]   saldo1_q, saldo1_d, saldo2_q, saldo2_d;
    logic [CONTA_W-1:0]   conta_q, conta_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 catraca_q, catraca_d;
    logic [1:0]           atendido_q, atendido_d;
    logic                 erro_q, erro_d;

    logic [1:0]           subida;
    logic [1:0]           grant;
    logic                 sel;
    logic [1:0]           carga;
    logic [SALDO_W-1:0]   saldo_sel;
    logic [SALDO_W-1:0]   saldo_novo;

    assign subida = passe & ~passe_q;

    arbitro_rr2 u_arbitro (
        .pend_i  (pend_q),
        .ult_i   (ult_q),
        .grant_o (grant)
    );

    always_ff @(posedge clk_2) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            passe_q    <= 2'b00;
            pend_q     <= 2'b00;
            ult_q      <= 1'b1;
            saldo1_q   <= '0;
            saldo2_q   <= '0;
            conta_q    <= '0;
            timer_q    <= '0;
            catraca_q  <= 1'b0;
            atendido_q <= 2'b00;
            erro_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            passe_q    <= passe;
            pend_q     <= pend_d;
            ult_q      <= ult_d;
            saldo1_q   <= saldo1_d;
            saldo2_q   <= saldo2_d;
            conta_q    <= conta_d;
            timer_q    <= timer_d;
            catraca_q  <= catraca_d;
            atendido_q <= atendido_d;
            erro_q     <= erro_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        // A new edge on a reader that is already pending is dropped.
        pend_d     = pend_q | (subida & ~pend_q);
        ult_d      = ult_q;
        saldo1_d   = saldo1_q;
        saldo2_d   = saldo2_q;
        conta_d    = conta_q;
        timer_d    = timer_q;
        catraca_d  = catraca_q;
        atendido_d = atendido_q;
        erro_d     = erro_q;
        sel        = grant[1];
        carga      = sel ? carrega2 : carrega1;
        saldo_sel  = sel ? saldo2_q : saldo1_q;
        saldo_novo = saldo_sel;

        case (estado_q)
            OCIOSO: begin
                if (grant != 2'b00) begin
                    ult_d  = sel;
                    pend_d = pend_d & ~grant;
                    if (carga != 2'b00) begin
                        saldo_novo = soma_sat(saldo_sel, carga, SALDO_LIM);
                    end else if (saldo_sel != '0) begin
                        saldo_novo = saldo_sel - 1'b1;
                        atendido_d = grant;
                        catraca_d  = 1'b1;
                        timer_d    = '0;
                        estado_d   = LIBERADA;
                    end else begin
                        erro_d   = 1'b1;
                        estado_d = NEGADO;
                    end
                    if (sel) saldo2_d = saldo_novo;
                    else     saldo1_d = saldo_novo;
                end
            end
            LIBERADA: begin
                if (giro) begin
                    conta_d    = (conta_q >= CONTA_LIM) ? conta_q : conta_q + 1'b1;
                    catraca_d  = 1'b0;
                    atendido_d = 2'b00;
                    estado_d   = OCIOSO;
                end else if (timer_q == TIMER_FIM) begin
                    catraca_d  = 1'b0;
                    atendido_d = 2'b00;
                    estado_d   = OCIOSO;
`ifdef CATRACA_ESTORNO_EN
                    if (atendido_q[1]) saldo2_d = soma_sat(saldo2_q, 2'd1, SALDO_LIM);
                    else               saldo1_d = soma_sat(saldo1_q, 2'd1, SALDO_LIM);
`endif
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            NEGADO: begin
                erro_d   = 1'b0;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_comb begin
        catraca  = catraca_q;
        atendido = atendido_q;
        erro     = erro_q;
        saldo1   = saldo1_q;
        saldo2   = saldo2_q;
        conta    = conta_q;
    end

endmodule

// File: tb/tb_catraca_controlador.sv
// Directed bench for catraca_controlador with default parameters.
module tb_catraca_controlador;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [1:0] passe;
    logic [1:0] carrega1;
    logic [1:0] carrega2;
    logic       giro;
    logic       catraca;
    logic [1:0] atendido;
    logic       erro;
    logic [2:0] saldo1;
    logic [2:0] saldo2;
    logic [6:0] conta;

    int n_checks = 0;
    int n_erros  = 0;

    catraca_controlador dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .passe    (passe),
        .carrega1 (carrega1),
        .carrega2 (carrega2),
        .giro     (giro),
        .catraca  (catraca),
        .atendido (atendido),
        .erro     (erro),
        .saldo1   (saldo1),
        .saldo2   (saldo2),
        .conta    (conta)
    );

    always #5 clk_2 = ~clk_2;

    task automatic verifica(input string tag, input logic [7:0] obs, input logic [7:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, esp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic faz_reset();
        reset = 1'b1;
        passe = 2'b00;
        carrega1 = 2'b00;
        carrega2 = 2'b00;
        giro = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic recarregar(input int i, input logic [1:0] c);
        passe = 2'b00;
        if (i == 0) carrega1 = c;
        else        carrega2 = c;
        tick();
        passe[i] = 1'b1;
        tick();
        tick();
        passe = 2'b00;
        carrega1 = 2'b00;
        carrega2 = 2'b00;
    endtask

    task automatic pedir(input int i);
        passe = 2'b00;
        tick();
        passe[i] = 1'b1;
        tick();
        tick();
        passe = 2'b00;
    endtask

    task automatic girar();
        giro = 1'b1;
        tick();
        giro = 1'b0;
    endtask

    initial begin
        logic [7:0] esp_estorno;

        // Reset values
        faz_reset();
        verifica("rst_catraca", 8'(catraca), 8'd0);
        verifica("rst_atendido", 8'(atendido), 8'd0);
        verifica("rst_erro", 8'(erro), 8'd0);
        verifica("rst_saldo1", 8'(saldo1), 8'd0);
        verifica("rst_conta", 8'(conta), 8'd0);

        // Recharge 3 then 3 again clamps at 5, then 1 more stays at 5
        recarregar(0, 2'd3);
        verifica("rec1_saldo1", 8'(saldo1), 8'd3);
        verifica("rec1_catraca", 8'(catraca), 8'd0);
        recarregar(0, 2'd3);
        verifica("rec2_saldo1", 8'(saldo1), 8'd5);
        recarregar(0, 2'd1);
        verifica("rec3_saldo1", 8'(saldo1), 8'd5);

        // Debit from 2: two-cycle latency to unlock
        faz_reset();
        recarregar(0, 2'd2);
        passe = 2'b00;
        tick();
        passe = 2'b01;
        tick();
        verifica("deb_lat1_catraca", 8'(catraca), 8'd0);
        tick();
        passe = 2'b00;
        verifica("deb_catraca", 8'(catraca), 8'd1);
        verifica("deb_atendido", 8'(atendido), 8'd1);
        verifica("deb_saldo1", 8'(saldo1), 8'd1);
        girar();
        verifica("giro_conta", 8'(conta), 8'd1);
        verifica("giro_catraca", 8'(catraca), 8'd0);
        verifica("giro_atendido", 8'(atendido), 8'd0);
        girar();
        verifica("giro_ocioso_conta", 8'(conta), 8'd1);

        // Simultaneous requests: reader 0 first, reader 1 after rotation
        faz_reset();
        recarregar(0, 2'd1);
        recarregar(1, 2'd1);
        verifica("rr_saldo2", 8'(saldo2), 8'd1);
        passe = 2'b00;
        tick();
        passe = 2'b11;
        tick();
        tick();
        passe = 2'b00;
        verifica("rr_atendido0", 8'(atendido), 8'd1);
        verifica("rr_saldo1", 8'(saldo1), 8'd0);
        girar();
        verifica("rr_conta1", 8'(conta), 8'd1);
        tick();
        verifica("rr_atendido1", 8'(atendido), 8'd2);
        verifica("rr_catraca1", 8'(catraca), 8'd1);
        verifica("rr_saldo2_deb", 8'(saldo2), 8'd0);
        girar();
        verifica("rr_conta2", 8'(conta), 8'd2);

        // Denial on card 1 with empty balance
        pedir(1);
        verifica("neg_erro", 8'(erro), 8'd1);
        verifica("neg_catraca", 8'(catraca), 8'd0);
        tick();
        verifica("neg_erro_fim", 8'(erro), 8'd0);

        // Timeout: unlock held exactly 4 cycles
        faz_reset();
        recarregar(0, 2'd1);
        pedir(0);
        verifica("to_c0", 8'(catraca), 8'd1);
        for (int k = 1; k < 4; k++) begin
            tick();
            verifica("to_hold", 8'(catraca), 8'd1);
        end
        tick();
        verifica("to_fim", 8'(catraca), 8'd0);
`ifdef CATRACA_ESTORNO_EN
        esp_estorno = 8'd1;
`else
        esp_estorno = 8'd0;
`endif
        verifica("to_saldo1", 8'(saldo1), esp_estorno);
        verifica("to_conta", 8'(conta), 8'd0);

        // Passenger counter saturation at 99 after 100 rotations
        faz_reset();
        for (int it = 0; it < 20; it++) begin
            recarregar(0, 2'd3);
            recarregar(0, 2'd3);
            repeat (5) begin
                pedir(0);
                girar();
            end
        end
        verifica("sat_conta", 8'(conta), 8'd99);
        verifica("sat_saldo1", 8'(saldo1), 8'd0);

        // Reset in the middle of an unlock clears everything, including pending reader 1
        recarregar(0, 2'd1);
        pedir(0);
        verifica("rl_catraca", 8'(catraca), 8'd1);
        passe = 2'b10;
        tick();
        passe = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        verifica("rl_catraca0", 8'(catraca), 8'd0);
        verifica("rl_atendido0", 8'(atendido), 8'd0);
        verifica("rl_saldo1", 8'(saldo1), 8'd0);
        verifica("rl_conta", 8'(conta), 8'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            verifica("rl_pend_erro", 8'(erro), 8'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
        $finish;
    end

endmodule

// File: doc/catraca_controlador.md
# catraca_controlador

Two-reader bus turnstile controller: arbitrates a single turnstile between two card readers, keeps a saturating credit balance per card, handles recharge, debit, denial and timed unlock, and counts passengers. Sits between the switch/sensor inputs of `top` and the LED/7-segment outputs, replacing the ad-hoc turnstile logic with a clean sequenced FSM.

## Interface
- `MAX_SALDO`, 5: balance ceiling per card, 1..7.
- `TEMPO_LIBERADA`, 4: cycles the turnstile stays unlocked waiting for rotation, 1..15.
- `MAX_CONTA`, 99: passenger counter ceiling, ≤127.

- `clk_2`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  **synchronous, active-high** reset.
- `passe`  in  2  card present at reader i (level; requests are rising-edge detected).
- `carrega1`  in  2  recharge amount presented with card 0 (0 = no recharge).
- `carrega2`  in  2  recharge amount presented with card 1.
- `giro`  in  1  turnstile rotation sensor, one-cycle or longer pulse.
- `catraca`  out  1  unlock command.
- `atendido`  out  2  one-hot: reader currently served; 0 when idle.
- `erro`  out  1  one-cycle pulse: debit denied, balance 0.
- `saldo1`, `saldo2`  out  3  current balance per card.
- `conta`  out  7  passengers counted, saturating.

## Operation
- Edge detect: register `passe_q`; rising edge on `passe[i]` sets `pend[i]`. Edge while `pend[i]` already set is ignored. `pend[i]` clears when reader i is serviced.
- States: OCIOSO, LIBERADA, NEGADO.
- OCIOSO: if any `pend`, grant one: single requester wins; both pending → reader ≠ `ult` (round-robin, `ult` = last granted). Grant updates `ult`. For granted i:
  - `carrega_i ≠ 0`: `saldo_i ← min(saldo_i + carrega_i, MAX_SALDO)` (4-bit sum, then clamp); stay OCIOSO; no unlock.
  - else `saldo_i > 0`: `saldo_i ← saldo_i − 1`, `atendido ← onehot(i)`, `catraca ← 1`, timer ← 0, go LIBERADA.
  - else: `erro ← 1`, go NEGADO.
- LIBERADA: timer increments each cycle. `giro=1` → `conta ← min(conta+1, MAX_CONTA)`, go OCIOSO. Else timer reaches `TEMPO_LIBERADA−1` → timeout, go OCIOSO (see Configuration). `giro` and timeout in the same cycle: `giro` wins, no refund. New edges still set `pend` and wait.
- NEGADO: one cycle; `erro ← 0`, go OCIOSO.
- `giro` outside LIBERADA is ignored.
- Recharge at `saldo = MAX_SALDO` leaves it unchanged.

## Timing
- Reset (synchronous): state OCIOSO, `catraca=0`, `atendido=0`, `erro=0`, `saldo1=saldo2=0`, `conta=0`, `pend=0`, `passe_q=0`, `ult=1` (reader 0 wins first tie).
- `passe[i]` rises before edge n → `pend[i]` after edge n → service at edge n+1: `catraca=1` visible after edge n+1 (2-cycle latency). Balance updates on the same edge.
- Unlock duration without `giro`: exactly `TEMPO_LIBERADA` cycles high.
- `giro` high before edge k in LIBERADA → `catraca=0`, `atendido=0`, `conta` updated after edge k.
- `erro` high exactly one cycle.
- Reset asserted mid-LIBERADA: `catraca=0` after that edge; balances, counter and pending requests cleared.
- All outputs registered.

## Configuration
- `CATRACA_ESTORNO_EN` defined: LIBERADA timeout refunds the debited credit to the served card (`saldo_i + 1`, cannot exceed `MAX_SALDO`), same edge as return to OCIOSO.
- Not defined: timeout forfeits the credit; balance unchanged.

## Structure
- `catraca_pkg`: `estado_t` enum {OCIOSO, LIBERADA, NEGADO}, default constants for `MAX_SALDO`, `TEMPO_LIBERADA`, `MAX_CONTA`, saldo width constant.
- Sub-module `arbitro_rr2`: 2-requester round-robin arbiter (inputs `pend`, `ult`; output one-hot grant), combinational.

## Test plan
- Reset, card 0 recharge `carrega1=3` twice → `saldo1` 3 then 5 (clamped); `catraca` stays 0.
- `saldo1=2`, card 0 edge with `carrega1=0` → `catraca=1` two cycles later, `atendido=01`, `saldo1=1`; `giro` pulse → `conta=1`, `catraca=0`.
- Both cards (balances 1 each) rise same cycle after reset → reader 0 served first, reader 1 served after reader 0 rotation; `atendido` 01 then 10.
- Card 1 with `saldo2=0`, no recharge → `erro` one-cycle pulse, `catraca` stays 0.
- `saldo1=1`, unlock, no `giro` for `TEMPO_LIBERADA=4` cycles → `catraca` high exactly 4 cycles; `saldo1=1` with `CATRACA_ESTORNO_EN`, 0 without.
- `conta=99`, another rotation → `conta` stays 99; reset during LIBERADA → all outputs 0 next cycle.
